// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR: maximal-length tap table
// and the single-step next-state function with all-zero lock-up guard.
package lfsr_pkg;

    localparam int unsigned LFSR_MIN_W = 2;
    localparam int unsigned LFSR_MAX_W = 32;

    // Bit i set means state bit i feeds the XOR; indexed by register width
    localparam logic [31:0] MAX_TAPS [2:32] = '{
        32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
        32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
        32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
        32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
        32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
        32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
        32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
        32'h2000_0029, 32'h4800_0000, 32'h8020_0003
    };

    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int unsigned width
    );
        logic [31:0] mask;
        logic [31:0] s;
        logic        fb;
        mask = 32'hFFFF_FFFF >> (32 - width);
        s    = state & mask;
        if (s == '0) begin
            return 32'd1;
        end
        fb = ^(s & taps);
        return ((s << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Loadable Fibonacci LFSR; pulses done when the state returns to the
// seed, marking one full period of the loaded sequence.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] TAPS       =
        DATA_WIDTH'(MAX_TAPS[DATA_WIDTH])
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done
);

    if (DATA_WIDTH < LFSR_MIN_W || DATA_WIDTH > LFSR_MAX_W ||
        !TAPS[DATA_WIDTH-1]) begin : g_bad_cfg
        $fatal(1, "lfsr_gen: DATA_WIDTH out of range or TAPS MSB clear");
    end

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t state_q, state_d;
    word_t seed_q, seed_d;
    logic  done_q, done_d;
    word_t step;
    word_t din_safe;

    assign step = word_t'(lfsr_next(32'(state_q), 32'(TAPS), DATA_WIDTH));

    // A zero seed would lock the register up, so it is replaced by 1
    assign din_safe = (data_in == '0) ? word_t'(1) : data_in;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = din_safe;
            seed_d  = din_safe;
        end else if (enable) begin
            state_d = step;
            done_d  = (step == seed_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= word_t'(1);
            seed_q  <= word_t'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            done_q  <= done_d;
        end
    end

    assign data_out = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen at default parameters (x^5+x^3+1).
// Expected values come from hand-worked vectors and a 5-bit shift model.
module tb_lfsr_gen;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [4:0] data_in;
    logic [4:0] data_out;
    logic       done;

    int checks   = 0;
    int failures = 0;

    lfsr_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] mstep(input logic [4:0] s);
        if (s == 5'd0) return 5'd1;
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  model;
        logic [31:0] seen;
        int          en_steps;
        logic        en;

        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        data_in = 5'd0;
        #12;
        check("reset_data", 32'(data_out), 32'h01);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load then first hand-computed steps
        tick();
        load    = 1'b1;
        data_in = 5'b10110;
        tick();
        check("load_data", 32'(data_out), 32'b10110);
        check("load_done", 32'(done), 32'h0);
        load   = 1'b0;
        enable = 1'b1;
        tick();
        check("step1", 32'(data_out), 32'b01100);
        tick();
        check("step2", 32'(data_out), 32'b11001);
        tick();
        check("step3", 32'(data_out), 32'b10011);

        // Two full periods from seed 10110
        enable = 1'b0;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        model  = 5'b10110;
        seen   = '0;
        for (int i = 0; i < 62; i++) begin
            tick();
            model = mstep(model);
            check("period_data", 32'(data_out), 32'(model));
            check("period_done", 32'(done), 32'(i == 30 || i == 61));
            if (i < 31) begin
                check("no_repeat", 32'(seen[data_out]), 32'h0);
                seen[data_out] = 1'b1;
            end
        end
        check("period_end", 32'(data_out), 32'b10110);
        check("all_values", 32'(seen), 32'hFFFF_FFFE);

        // Load beats enable; held load keeps state and suppresses done
        load    = 1'b1;
        data_in = 5'b01010;
        tick();
        check("prio_data", 32'(data_out), 32'b01010);
        check("prio_done", 32'(done), 32'h0);
        tick();
        check("hold_load_data", 32'(data_out), 32'b01010);
        check("hold_load_done", 32'(done), 32'h0);

        // Zero seed becomes 1
        data_in = 5'd0;
        tick();
        check("zero_load", 32'(data_out), 32'h01);
        load  = 1'b0;
        model = 5'd1;
        for (int i = 0; i < 31; i++) begin
            tick();
            model = mstep(model);
            check("zero_data", 32'(data_out), 32'(model));
            check("zero_done", 32'(done), 32'(i == 30));
        end
        check("zero_end", 32'(data_out), 32'h01);

        // Random enable gaps
        enable  = 1'b0;
        load    = 1'b1;
        data_in = 5'b00111;
        tick();
        load     = 1'b0;
        model    = 5'b00111;
        en_steps = 0;
        for (int c = 0; c < 400 && en_steps < 31; c++) begin
            en     = 1'($urandom_range(0, 1));
            enable = en;
            tick();
            if (en) begin
                model = mstep(model);
                en_steps++;
            end
            check("gap_data", 32'(data_out), 32'(model));
            check("gap_done", 32'(done), 32'(en && en_steps == 31));
        end
        check("gap_budget", 32'(en_steps), 32'd31);

        // Asynchronous reset mid-cycle, then run from seed 1
        enable = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data_out), 32'h01);
        check("async_rst_done", 32'(done), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst1", 32'(data_out), 32'b00010);
        tick();
        check("post_rst2", 32'(data_out), 32'b00100);
        tick();
        check("post_rst3", 32'(data_out), 32'b01001);
        check("post_rst_done", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
